// File: rtl/cnn_mac_pipe_if.sv
// rtl/cnn_mac_pipe_if.sv - operand/result bundle for cnn_mac_pipe; sat_flag exists only with CNN_MAC_PIPE_SAT_EN
interface cnn_mac_pipe_if #(
   parameter int DIN0_WIDTH = 14,
   parameter int DIN1_WIDTH = 6,
   parameter int ACC_WIDTH  = 28
);
   logic                         ce;
   logic                         din_valid;
   logic                         din_first;
   logic                         din_last;
   logic signed [DIN0_WIDTH-1:0] din0;
   logic signed [DIN1_WIDTH-1:0] din1;
   logic signed [ACC_WIDTH-1:0]  dout;
   logic                         dout_valid;
`ifdef CNN_MAC_PIPE_SAT_EN
   logic                         sat_flag;

   modport master (output ce, din_valid, din_first, din_last, din0, din1,
                   input  dout, dout_valid, sat_flag);
   modport slave  (input  ce, din_valid, din_first, din_last, din0, din1,
                   output dout, dout_valid, sat_flag);
`else
   modport master (output ce, din_valid, din_first, din_last, din0, din1,
                   input  dout, dout_valid);
   modport slave  (input  ce, din_valid, din_first, din_last, din0, din1,
                   output dout, dout_valid);
`endif
endinterface

// File: rtl/cnn_mac_pipe.sv
// rtl/cnn_mac_pipe.sv - 3-stage signed MAC with first/last framing; CNN_MAC_PIPE_SAT_EN selects saturating add
module cnn_mac_pipe #(
   parameter int DIN0_WIDTH = 14,
   parameter int DIN1_WIDTH = 6,
   parameter int ACC_WIDTH  = 28
) (
   input logic           ap_clk,
   input logic           ap_rst_n,
   cnn_mac_pipe_if.slave bus
);
   localparam int PROD_WIDTH = DIN0_WIDTH + DIN1_WIDTH;

   logic signed [DIN0_WIDTH-1:0] s1_din0;
   logic signed [DIN1_WIDTH-1:0] s1_din1;
   logic                         s1_valid, s1_first, s1_last;
   logic signed [PROD_WIDTH-1:0] s2_prod;
   logic                         s2_valid, s2_first, s2_last;
   logic signed [ACC_WIDTH-1:0]  acc;
   logic                         s3_last;
   logic signed [ACC_WIDTH-1:0]  prod_ext, sum, acc_next;

`ifdef CNN_MAC_PIPE_SAT_EN
   localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
   logic ovf;
   logic sticky;
`endif

   always_comb begin
      prod_ext = ACC_WIDTH'(s2_prod);
      sum      = acc + prod_ext;
`ifdef CNN_MAC_PIPE_SAT_EN
      // same-sign operands producing an opposite-sign sum is the only overflow case
      ovf      = (acc[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                 (sum[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);
      acc_next = ovf ? (acc[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX) : sum;
`else
      acc_next = sum;
`endif
   end

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         s1_din0        <= '0;
         s1_din1        <= '0;
         s1_valid       <= 1'b0;
         s1_first       <= 1'b0;
         s1_last        <= 1'b0;
         s2_prod        <= '0;
         s2_valid       <= 1'b0;
         s2_first       <= 1'b0;
         s2_last        <= 1'b0;
         acc            <= '0;
         s3_last        <= 1'b0;
         bus.dout       <= '0;
         bus.dout_valid <= 1'b0;
`ifdef CNN_MAC_PIPE_SAT_EN
         sticky         <= 1'b0;
         bus.sat_flag   <= 1'b0;
`endif
      end else if (bus.ce) begin
         s1_din0  <= bus.din0;
         s1_din1  <= bus.din1;
         s1_valid <= bus.din_valid;
         s1_first <= bus.din_valid & bus.din_first;
         s1_last  <= bus.din_valid & bus.din_last;

         s2_prod  <= s1_din0 * s1_din1;
         s2_valid <= s1_valid;
         s2_first <= s1_first;
         s2_last  <= s1_last;

         if (s2_valid) begin
            acc <= s2_first ? prod_ext : acc_next;
`ifdef CNN_MAC_PIPE_SAT_EN
            sticky <= s2_first ? 1'b0 : (sticky | ovf);
`endif
         end
         s3_last <= s2_last;

         // dout keeps the last frame result between pulses
         bus.dout_valid <= s3_last;
         if (s3_last) begin
            bus.dout <= acc;
`ifdef CNN_MAC_PIPE_SAT_EN
            bus.sat_flag <= sticky;
`endif
         end
      end
   end
endmodule

// File: tb/tb_cnn_mac_pipe.sv
// tb/tb_cnn_mac_pipe.sv - directed + random check of cnn_mac_pipe (ACC 28 and 20) against a frame-level model
module tb_cnn_mac_pipe;
   logic clk;
   logic rst_n, ce, vld, fst, lst;
   int   xa, yb;

   cnn_mac_pipe_if #(.DIN0_WIDTH(14), .DIN1_WIDTH(6), .ACC_WIDTH(28)) bus28 ();
   cnn_mac_pipe_if #(.DIN0_WIDTH(14), .DIN1_WIDTH(6), .ACC_WIDTH(20)) bus20 ();

   assign bus28.ce = ce;   assign bus20.ce = ce;
   assign bus28.din_valid = vld;   assign bus20.din_valid = vld;
   assign bus28.din_first = fst;   assign bus20.din_first = fst;
   assign bus28.din_last = lst;    assign bus20.din_last = lst;
   assign bus28.din0 = 14'(xa);    assign bus20.din0 = 14'(xa);
   assign bus28.din1 = 6'(yb);     assign bus20.din1 = 6'(yb);

   cnn_mac_pipe #(.DIN0_WIDTH(14), .DIN1_WIDTH(6), .ACC_WIDTH(28)) dut28 (
      .ap_clk(clk), .ap_rst_n(rst_n), .bus(bus28));
   cnn_mac_pipe #(.DIN0_WIDTH(14), .DIN1_WIDTH(6), .ACC_WIDTH(20)) dut20 (
      .ap_clk(clk), .ap_rst_n(rst_n), .bus(bus20));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      longint      d28;
      longint      d20;
      bit          s28;
      bit          s20;
      int unsigned at;
   } exp_t;

   exp_t        exp_q[$];
   longint      acc_m[2];
   bit          sat_m[2];
   bit          exp_dv;
   int unsigned ce_edges;
   longint      last28, last20;
   bit          lsat28, lsat20;
   int          n_checks, n_fail;

   task automatic check(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic longint wrapw(input longint v, input int w);
      longint m = longint'(1) <<< w;
      longint r = v & (m - 1);
      if (r >= (m >>> 1)) r = r - m;
      return r;
   endfunction

   // frame-level arithmetic: what the accumulator should hold after this beat, per width
   task automatic model_beat(input bit f, input bit l, input int x, input int y);
      longint p = longint'(x) * longint'(y);
      for (int k = 0; k < 2; k++) begin
         int     w = (k == 0) ? 28 : 20;
         longint mx = (longint'(1) <<< (w - 1)) - 1;
         longint mn = -(longint'(1) <<< (w - 1));
         longint s;
         if (f) begin
            acc_m[k] = p;
            sat_m[k] = 1'b0;
         end else begin
            s = acc_m[k] + p;
`ifdef CNN_MAC_PIPE_SAT_EN
            if (s > mx) begin s = mx; sat_m[k] = 1'b1; end
            if (s < mn) begin s = mn; sat_m[k] = 1'b1; end
`else
            s = wrapw(s, w);
`endif
            acc_m[k] = s;
         end
      end
      if (l) exp_q.push_back('{acc_m[0], acc_m[1], sat_m[0], sat_m[1], ce_edges + 3});
   endtask

   task automatic step();
      bit r = rst_n, c = ce, v = vld, f = fst, l = lst;
      int x = xa, y = yb;
      exp_t e;
      @(posedge clk);
      #1;
      if (!r) begin
         exp_q.delete();
         acc_m[0] = 0; acc_m[1] = 0; sat_m[0] = 0; sat_m[1] = 0;
         exp_dv = 1'b0;
         check("rst_dout28", longint'(bus28.dout), 0);
         check("rst_dv28", longint'(bus28.dout_valid), 0);
         check("rst_dout20", longint'(bus20.dout), 0);
         check("rst_dv20", longint'(bus20.dout_valid), 0);
      end else if (c) begin
         ce_edges++;
         exp_dv = (exp_q.size() > 0) && (exp_q[0].at == ce_edges);
         check("dout_valid28", longint'(bus28.dout_valid), longint'(exp_dv));
         check("dout_valid20", longint'(bus20.dout_valid), longint'(exp_dv));
         if (exp_dv) begin
            e = exp_q.pop_front();
            last28 = longint'(bus28.dout);
            last20 = longint'(bus20.dout);
            check("dout28", last28, e.d28);
            check("dout20", last20, e.d20);
`ifdef CNN_MAC_PIPE_SAT_EN
            lsat28 = bus28.sat_flag;
            lsat20 = bus20.sat_flag;
            check("sat28", longint'(lsat28), longint'(e.s28));
            check("sat20", longint'(lsat20), longint'(e.s20));
`endif
         end
         if (v) model_beat(f, l, x, y);
      end else begin
         check("dv_hold_ce0", longint'(bus28.dout_valid), longint'(exp_dv));
      end
   endtask

   task automatic beat(input bit v, input bit f, input bit l, input int x, input int y);
      vld = v; fst = f; lst = l; xa = x; yb = y;
      step();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) beat(1'b0, 1'b1, 1'b1, 0, 0);
   endtask

   initial begin
      n_checks = 0; n_fail = 0; ce_edges = 0; exp_dv = 0;
      last28 = 0; last20 = 0; lsat28 = 0; lsat20 = 0;
      rst_n = 1'b0; ce = 1'b0;
      idle(2);
      rst_n = 1'b1; ce = 1'b1;
      idle(2);

      beat(1, 1, 1, 100, -3);
      idle(5);
      check("plan_single", last28, -300);

      beat(1, 1, 0, 1000, 5);
      beat(1, 0, 0, -2000, 3);
      beat(1, 0, 0, 7, -32);
      beat(1, 0, 1, 8191, 31);
      idle(6);
      check("plan_four28", last28, 252697);
      check("plan_four20", last20, 252697);

      beat(1, 1, 0, -8192, -32);
      idle(1);
      beat(1, 0, 1, -8192, -32);
      idle(5);
      check("plan_ext28", last28, 524288);
`ifdef CNN_MAC_PIPE_SAT_EN
      check("plan_ext20_sat", last20, 524287);
      check("plan_ext20_flag", longint'(lsat20), 1);
`else
      check("plan_ext20_wrap", last20, -524288);
`endif
      beat(1, 1, 1, 1, 1);
      idle(5);
      check("plan_one20", last20, 1);
`ifdef CNN_MAC_PIPE_SAT_EN
      check("plan_flag_clear", longint'(lsat20), 0);
`endif

      beat(1, 1, 0, -8192, -32);
      ce = 1'b0;
      beat(1, 1, 1, 55, 7);
      beat(1, 0, 1, 55, 7);
      ce = 1'b1;
      beat(1, 0, 1, -8192, -32);
      beat(0, 0, 0, 0, 0);
      ce = 1'b0;
      idle(3);
      ce = 1'b1;
      idle(4);
      check("plan_ce_stall", last28, 524288);

      beat(1, 1, 1, 3, 4);
      beat(1, 1, 0, -5, 6);
      beat(1, 0, 1, 2, 2);
      beat(0, 0, 0, 0, 0);
      check("plan_b2b_a", last28, 12);
      idle(3);
      check("plan_b2b_b", last28, -26);

      beat(1, 1, 0, 11, 3);
      beat(1, 0, 1, 9, 2);
      rst_n = 1'b0;
      idle(1);
      rst_n = 1'b1;
      idle(6);
      beat(1, 1, 1, 1, 1);
      idle(5);
      check("plan_after_rst", last28, 1);

      for (int i = 0; i < 600; i++) begin
         ce    = ($urandom_range(0, 9) != 0);
         rst_n = ($urandom_range(0, 199) != 0);
         beat($urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 3) == 0,
              int'($urandom_range(0, 16383)) - 8192, int'($urandom_range(0, 63)) - 32);
      end
      rst_n = 1'b1; ce = 1'b1;
      idle(8);
      check("queue_drained", longint'(exp_q.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
